// File: rtl/mlp_load_sequencer.sv
// mlp_load_sequencer
//   Autonomous load controller for MLP_acc_top. On start it walks the staging
//   memory, one read outstanding at a time, and replays each word as a single
//   load beat in the order the accelerator expects:
//     layer 0      : per row, BEATS input beats then BEATS weight beats
//     layers 1..N  : per row, BEATS weight beats only
//   After the last row of a layer it waits for acc_layer_done_i before moving on.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start_i, last_layer_i run request (sampled in IDLE only) and last layer index
//   busy_o, done_o        run in progress / one-cycle end-of-run pulse
//   mem_req_o, mem_sel_o, mem_addr_o   staging read request (sel 1 = input buffer)
//   mem_rvalid_i, mem_rdata_i          staging read response, any latency >= 1
//   acc_layer_done_i      accelerator finished the current layer
//   load_en_o, load_payload_o, load_type_o, input_load_number_o,
//   layer_number_o, weight_number_o    accelerator load interface
//
// Build option
//   LOAD_SEQ_PERF_EN  adds perf_cycles_o, a count of busy cycles for the last run.

module mlp_load_sequencer #(
    parameter int ROWS   = 16,
    parameter int BEATS  = 8,
    parameter int ADDR_W = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [2:0]                 last_layer_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       mem_req_o,
    output logic                       mem_sel_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    input  logic                       mem_rvalid_i,
    input  logic [31:0]                mem_rdata_i,
    input  logic                       acc_layer_done_i,
    output logic                       load_en_o,
    output logic [31:0]                load_payload_o,
    output logic                       load_type_o,
    output logic [$clog2(ROWS)-1:0]    input_load_number_o,
    output logic [2:0]                 layer_number_o,
    output logic [$clog2(BEATS)-1:0]   weight_number_o
`ifdef LOAD_SEQ_PERF_EN
    ,
    output logic [31:0]                perf_cycles_o
`endif
);

    localparam int RW           = $clog2(ROWS);
    localparam int BW           = $clog2(BEATS);
    localparam int LAYER_STRIDE = ROWS * BEATS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_LWAIT,
        S_DONE
    } state_t;

    state_t          state;
    logic [2:0]      last_layer;
    logic [2:0]      layer;
    logic [RW-1:0]   row;
    logic [BW-1:0]   beat;
    logic            phase_in;      // 1 = input phase, 0 = weight phase

    logic [BW-1:0]   nxt_beat;
    logic [RW-1:0]   nxt_row;
    logic            nxt_phase;
    logic            layer_end;

    // Input words live at row*BEATS+beat of the input buffer; weight words are
    // laid out one ROWS*BEATS block per layer in the weight buffer.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic sel, input logic [2:0] lyr,
                                                    input logic [RW-1:0] r, input logic [BW-1:0] b);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(r) * ADDR_W'(BEATS) + ADDR_W'(b);
        if (!sel)
            a = a + ADDR_W'(lyr) * ADDR_W'(LAYER_STRIDE);
        return a;
    endfunction

    // Where the counters go after the beat now being issued.
    always_comb begin
        nxt_beat  = beat + 1'b1;
        nxt_row   = row;
        nxt_phase = phase_in;
        layer_end = 1'b0;
        if (beat == BW'(BEATS - 1)) begin
            nxt_beat = '0;
            if (phase_in) begin
                nxt_phase = 1'b0;
            end else begin
                // Only layer 0 goes back to an input phase for the next row.
                nxt_phase = (layer == 3'd0);
                if (row == RW'(ROWS - 1)) begin
                    nxt_row   = '0;
                    layer_end = 1'b1;
                end else begin
                    nxt_row = row + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_IDLE;
            last_layer          <= '0;
            layer               <= '0;
            row                 <= '0;
            beat                <= '0;
            phase_in            <= 1'b0;
            busy_o              <= 1'b0;
            done_o              <= 1'b0;
            mem_req_o           <= 1'b0;
            mem_sel_o           <= 1'b0;
            mem_addr_o          <= '0;
            load_en_o           <= 1'b0;
            load_payload_o      <= '0;
            load_type_o         <= 1'b0;
            input_load_number_o <= '0;
            layer_number_o      <= '0;
            weight_number_o     <= '0;
        end else begin
            mem_req_o <= 1'b0;
            load_en_o <= 1'b0;
            done_o    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        last_layer <= last_layer_i;
                        layer      <= '0;
                        row        <= '0;
                        beat       <= '0;
                        phase_in   <= 1'b1;
                        busy_o     <= 1'b1;
                        mem_req_o  <= 1'b1;
                        mem_sel_o  <= 1'b1;
                        mem_addr_o <= '0;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_WAIT;
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        load_payload_o      <= mem_rdata_i;
                        load_en_o           <= 1'b1;
                        // Sideband only changes here, so it stays put between beats.
                        load_type_o         <= phase_in;
                        input_load_number_o <= row;
                        layer_number_o      <= layer;
                        weight_number_o     <= phase_in ? '0 : beat;
                        state               <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    beat     <= nxt_beat;
                    row      <= nxt_row;
                    phase_in <= nxt_phase;
                    if (layer_end) begin
                        state <= S_LWAIT;
                    end else begin
                        mem_req_o  <= 1'b1;
                        mem_sel_o  <= nxt_phase;
                        mem_addr_o <= beat_addr(nxt_phase, layer, nxt_row, nxt_beat);
                        state      <= S_FETCH;
                    end
                end
                S_LWAIT: begin
                    if (acc_layer_done_i) begin
                        if (layer == last_layer) begin
                            done_o <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            layer      <= layer + 3'd1;
                            phase_in   <= 1'b0;
                            mem_req_o  <= 1'b1;
                            mem_sel_o  <= 1'b0;
                            mem_addr_o <= beat_addr(1'b0, layer + 3'd1, '0, '0);
                            state      <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef LOAD_SEQ_PERF_EN
    // Counts every cycle busy_o is high, including the done cycle; holds after.
    always_ff @(posedge clk) begin
        if (rst)
            perf_cycles_o <= '0;
        else if (state == S_IDLE && start_i)
            perf_cycles_o <= '0;
        else if (busy_o)
            perf_cycles_o <= perf_cycles_o + 32'd1;
    end
`else
    // No cycle counter in this build.
`endif

endmodule

// File: doc/mlp_load_sequencer.md
Name: mlp_load_sequencer

Overview:
Autonomous load controller that drives the MLP_acc_top load interface, replacing bench-driven stimulus.
- On a start command it fetches packed input and weight pairs from the on-chip staging memory.
- It replays them in the accelerator's required order: layer 0 interleaves 8 input beats and 8 weight beats per row; layers 1..N carry weight beats only.
- Between layers it waits for the accelerator's layer-done pulse.
- It sits between the staging memory and MLP_acc_top.

Parameters:
ROWS, 16, rows per matrix (input_load_number range)
BEATS, 8, 32-bit beats per row (2 x 16-bit elements per beat)
ADDR_W, 11, staging memory word address width

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-high
start_i  in  1  start pulse; sampled only in IDLE
last_layer_i  in  3  index of last layer to run (0..7); sampled with start_i
busy_o  out  1  high from the cycle after an accepted start until done_o
done_o  out  1  one-cycle pulse at end of run
mem_req_o  out  1  read request, one cycle, one outstanding at a time
mem_sel_o  out  1  1 = input buffer, 0 = weight buffer; valid with mem_req_o
mem_addr_o  out  ADDR_W  word address; valid with mem_req_o
mem_rvalid_i  in  1  read data valid, arbitrary latency >= 1
mem_rdata_i  in  32  {odd element, even element}
acc_layer_done_i  in  1  accelerator pulse: current layer finished
load_en_o  out  1  beat valid, exactly one cycle per beat
load_payload_o  out  32  beat data (registered mem_rdata_i)
load_type_o  out  1  1 = input, 0 = weight
input_load_number_o  out  4  current row
layer_number_o  out  3  current layer
weight_number_o  out  3  weight beat index within row

Behaviour:
- Reset: state IDLE, all outputs 0, all counters 0. rst mid-run aborts immediately with no done_o; late mem_rvalid_i is ignored.
- States and transitions:
  - IDLE -> FETCH on start_i. Latch last_layer_i. Clear layer, row, beat and phase; phase = INPUT.
  - FETCH: mem_req_o = 1 for one cycle -> WAIT.
  - WAIT: hold until mem_rvalid_i. Capture mem_rdata_i into the payload register -> ISSUE.
  - ISSUE: load_en_o = 1, then advance counters -> FETCH, LWAIT or DONE.
  - LWAIT: wait for acc_layer_done_i -> FETCH (next layer) or DONE (last layer).
  - DONE: done_o = 1 for one cycle -> IDLE.
- Addressing:
  - Input beats: mem_sel_o = 1, addr = row*8 + beat.
  - Weight beats: mem_sel_o = 0, addr = layer*128 + row*8 + beat.
- Sequencing:
  - Layer 0: per row, beats 0..7 with phase INPUT (load_type_o = 1, weight_number_o = 0), then beats 0..7 with phase WEIGHT (load_type_o = 0, weight_number_o = beat).
  - Layers >= 1: WEIGHT phase only.
  - After row 15's last weight beat, go to LWAIT.
- Sideband hold: load_type_o, input_load_number_o, layer_number_o and weight_number_o are held stable from ISSUE until the next ISSUE.
- Latency: 3 cycles per beat when memory latency is 1.
  - Layer 0: 256 beats = 768 cycles.
  - Layers >= 1: 128 beats = 384 cycles each.
- Boundary conditions:
  - mem_rvalid_i outside WAIT: ignored.
  - acc_layer_done_i outside LWAIT: ignored, not latched.
  - start_i while busy: ignored.
  - last_layer_i = 0: layer 0 only.
  - Row, beat and layer counters wrap only under state control; no modular overflow is reachable.

Optional Feature:
LOAD_SEQ_PERF_EN
- Defined: adds output perf_cycles_o[31:0], cleared on accepted start and incremented every busy cycle. It holds its value after done and resets to 0 on rst.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- rst held 3 cycles mid-run, then released -> all outputs 0, state IDLE, no done_o, next start runs cleanly.
- start_i with last_layer_i = 0, memory latency 1, acc_layer_done_i 5 cycles after the last beat:
  - 256 load_en_o pulses, in order 8 input beats then 8 weight beats per row, rows 0..15.
  - done_o pulses 1 cycle after acc_layer_done_i.
  - With LOAD_SEQ_PERF_EN: perf_cycles_o = 774.
- last_layer_i = 2 -> layers 1 and 2 each give 128 weight-only beats with load_type_o = 0. First layer-1 mem_addr_o = 128; last layer-2 address = 383.
- Random memory latency 1..6 -> payload matches memory content at the expected address for every beat; load_en_o is never asserted twice per fetch.
- start_i pulsed while busy, plus spurious acc_layer_done_i during FETCH -> both ignored; beat count unchanged.
- Run finished, start_i again -> second identical run; sideband outputs restart at row 0, layer 0.
